// File: rtl/multdiv_ctrl.sv
// Sequencing controller for the radix-4 Booth multiplier and restoring
// divider: load/step strobes, step counting, divide-by-zero and result strobe.
module multdiv_ctrl #(
   parameter int MULT_STEPS = 16,
   parameter int DIV_STEPS  = 32,
   parameter int CNT_W      = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   input  logic             divisor_zero,
   input  logic             flush,
   output logic             mult_load,
   output logic             mult_shift_ena,
   output logic             div_load,
   output logic             div_shift_ena,
   output logic             dp_ena,
   output logic [CNT_W-1:0] step_count,
   output logic             busy,
   output logic             data_resultRDY,
   output logic             data_exception,
   output logic             result_is_div
);

   typedef enum logic [1:0] {
      IDLE,
      MRUN,
      DRUN,
      DONE
   } state_t;

   localparam logic [CNT_W-1:0] M_LAST = CNT_W'(MULT_STEPS - 1);
   localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DIV_STEPS - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             exc_q, exc_d;
   logic             div_q, div_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         exc_q   <= 1'b0;
         div_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         exc_q   <= exc_d;
         div_q   <= div_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      exc_d          = exc_q;
      div_d          = div_q;
      mult_load      = 1'b0;
      div_load       = 1'b0;
      mult_shift_ena = 1'b0;
      div_shift_ena  = 1'b0;
      busy           = 1'b1;
      data_resultRDY = 1'b0;
      data_exception = 1'b0;
      result_is_div  = 1'b0;

      unique case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (ctrl_MULT) begin
               mult_load = 1'b1;
               state_d   = MRUN;
               cnt_d     = '0;
               exc_d     = 1'b0;
               div_d     = 1'b0;
            end else if (ctrl_DIV) begin
               cnt_d = '0;
               div_d = 1'b1;
               if (divisor_zero) begin
                  exc_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  div_load = 1'b1;
                  exc_d    = 1'b0;
                  state_d  = DRUN;
               end
            end
         end
         MRUN: begin
            mult_shift_ena = 1'b1;
            cnt_d          = cnt_q + 1'b1;
            if (cnt_q == M_LAST)
               state_d = DONE;
         end
         DRUN: begin
            div_shift_ena = 1'b1;
            cnt_d         = cnt_q + 1'b1;
            if (cnt_q == D_LAST)
               state_d = DONE;
         end
         DONE: begin
            data_resultRDY = 1'b1;
            data_exception = exc_q;
            result_is_div  = div_q;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // An aborted start must not disturb the datapath registers
      if (flush || reset) begin
         state_d   = IDLE;
         cnt_d     = '0;
         mult_load = 1'b0;
         div_load  = 1'b0;
      end

      dp_ena = mult_load | div_load | mult_shift_ena | div_shift_ena;
   end

   assign step_count = cnt_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl: directed starts, flush and reset aborts,
// result strobes checked by a decoupled monitor.
module tb_multdiv_ctrl;

   localparam int CW = 6;

   logic          clock = 1'b0;
   logic          reset;
   logic          ctrl_MULT;
   logic          ctrl_DIV;
   logic          divisor_zero;
   logic          flush;
   logic          mult_load;
   logic          mult_shift_ena;
   logic          div_load;
   logic          div_shift_ena;
   logic          dp_ena;
   logic [CW-1:0] step_count;
   logic          busy;
   logic          data_resultRDY;
   logic          data_exception;
   logic          result_is_div;

   multdiv_ctrl #(
      .MULT_STEPS(16),
      .DIV_STEPS (32),
      .CNT_W     (CW)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .ctrl_MULT     (ctrl_MULT),
      .ctrl_DIV      (ctrl_DIV),
      .divisor_zero  (divisor_zero),
      .flush         (flush),
      .mult_load     (mult_load),
      .mult_shift_ena(mult_shift_ena),
      .div_load      (div_load),
      .div_shift_ena (div_shift_ena),
      .dp_ena        (dp_ena),
      .step_count    (step_count),
      .busy          (busy),
      .data_resultRDY(data_resultRDY),
      .data_exception(data_exception),
      .result_is_div (result_is_div)
   );

   always #5 clock = ~clock;

   typedef struct {
      int cyc;
      bit is_div;
      bit exc;
      int step;
   } exp_t;

   exp_t sbq[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   n_ms, n_ds, n_busy, ms_first, ms_last;
   int   s;

   always @(posedge clock) cyc <= cyc + 1;

   function automatic void check(string name, int got, int exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  name, got, exp, cyc);
      end
   endfunction

   // Monitor: strobe accounting, invariants and the result scoreboard
   always @(negedge clock) begin
      exp_t e;
      if (mult_shift_ena) begin
         n_ms++;
         if (ms_first < 0) ms_first = cyc;
         ms_last = cyc;
      end
      if (div_shift_ena) n_ds++;
      if (busy) n_busy++;
      check("shift_excl", int'(mult_shift_ena & div_shift_ena), 0);
      check("load_excl", int'(mult_load & div_load), 0);
      if (data_resultRDY) begin
         if (sbq.size() == 0) begin
            check("unexpected_rdy", cyc, -1);
         end else begin
            e = sbq.pop_front();
            check("rdy_cycle", cyc, e.cyc);
            check("rdy_is_div", int'(result_is_div), int'(e.is_div));
            check("rdy_exc", int'(data_exception), int'(e.exc));
            if (e.step >= 0) check("rdy_step", int'(step_count), e.step);
         end
      end else begin
         check("flags_outside_done",
               int'({data_exception, result_is_div}), 0);
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clr();
      n_ms     = 0;
      n_ds     = 0;
      n_busy   = 0;
      ms_first = -1;
      ms_last  = -1;
   endtask

   initial begin
      reset        = 1'b1;
      ctrl_MULT    = 1'b0;
      ctrl_DIV     = 1'b0;
      divisor_zero = 1'b0;
      flush        = 1'b0;
      clr();
      repeat (2) tick();
      @(negedge clock);
      check("rst_busy", int'(busy), 0);
      check("rst_rdy", int'(data_resultRDY), 0);
      check("rst_step", int'(step_count), 0);
      check("rst_strobes",
            int'({mult_load, div_load, mult_shift_ena,
                  div_shift_ena, dp_ena}), 0);
      tick();
      reset = 1'b0;
      tick();

      // Multiply
      clr();
      s = cyc;
      ctrl_MULT = 1'b1;
      sbq.push_back('{s + 17, 1'b0, 1'b0, 16});
      @(negedge clock);
      check("mul_load", int'(mult_load), 1);
      check("mul_no_dload", int'(div_load), 0);
      check("mul_dp_ena", int'(dp_ena), 1);
      check("mul_busy_c0", int'(busy), 0);
      tick();
      ctrl_MULT = 1'b0;
      repeat (4) tick();
      @(negedge clock);
      check("mul_step_c5", int'(step_count), 4);
      repeat (13) tick();
      @(negedge clock);
      check("mul_nshift", n_ms, 16);
      check("mul_first", ms_first, s + 1);
      check("mul_last", ms_last, s + 16);
      check("mul_nbusy", n_busy, 17);
      check("mul_busy_c18", int'(busy), 0);
      check("mul_step_hold", int'(step_count), 16);

      // Divide
      tick();
      clr();
      s = cyc;
      ctrl_DIV = 1'b1;
      sbq.push_back('{s + 33, 1'b1, 1'b0, 32});
      @(negedge clock);
      check("div_load", int'(div_load), 1);
      check("div_no_mload", int'(mult_load), 0);
      check("div_dp_ena", int'(dp_ena), 1);
      tick();
      ctrl_DIV = 1'b0;
      repeat (33) tick();
      @(negedge clock);
      check("div_nshift", n_ds, 32);
      check("div_nbusy", n_busy, 33);
      check("div_no_mshift", n_ms, 0);

      // Divide by zero
      tick();
      clr();
      s = cyc;
      ctrl_DIV = 1'b1;
      divisor_zero = 1'b1;
      sbq.push_back('{s + 1, 1'b1, 1'b1, -1});
      @(negedge clock);
      check("dz_no_load", int'(div_load), 0);
      check("dz_dp_ena", int'(dp_ena), 0);
      tick();
      ctrl_DIV = 1'b0;
      divisor_zero = 1'b0;
      @(negedge clock);
      check("dz_busy_c1", int'(busy), 1);
      tick();
      @(negedge clock);
      check("dz_idle_c2", int'(busy), 0);
      check("dz_nshift", n_ds, 0);

      // Simultaneous start, then a divide pulse mid-multiply
      tick();
      clr();
      s = cyc;
      ctrl_MULT = 1'b1;
      ctrl_DIV = 1'b1;
      sbq.push_back('{s + 17, 1'b0, 1'b0, 16});
      @(negedge clock);
      check("sim_mload", int'(mult_load), 1);
      check("sim_no_dload", int'(div_load), 0);
      tick();
      ctrl_MULT = 1'b0;
      ctrl_DIV = 1'b0;
      repeat (4) tick();
      ctrl_DIV = 1'b1;
      @(negedge clock);
      check("busy_div_ignored", int'(div_load), 0);
      tick();
      ctrl_DIV = 1'b0;
      repeat (12) tick();
      @(negedge clock);
      check("sim_no_dshift", n_ds, 0);
      check("sim_nshift", n_ms, 16);
      check("sim_busy_c18", int'(busy), 0);

      // Flush mid-divide, restart multiply
      tick();
      clr();
      s = cyc;
      ctrl_DIV = 1'b1;
      tick();
      ctrl_DIV = 1'b0;
      repeat (9) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      ctrl_MULT = 1'b1;
      sbq.push_back('{s + 28, 1'b0, 1'b0, 16});
      @(negedge clock);
      check("fl_busy_c11", int'(busy), 0);
      check("fl_step_c11", int'(step_count), 0);
      check("fl_mload_c11", int'(mult_load), 1);
      tick();
      ctrl_MULT = 1'b0;
      repeat (17) tick();
      @(negedge clock);
      check("fl_busy_end", int'(busy), 0);
      check("fl_nshift_div", n_ds, 10);

      // Reset mid-multiply
      tick();
      clr();
      ctrl_MULT = 1'b1;
      tick();
      ctrl_MULT = 1'b0;
      repeat (7) tick();
      reset = 1'b1;
      tick();
      @(negedge clock);
      check("rm_busy", int'(busy), 0);
      check("rm_step", int'(step_count), 0);
      check("rm_strobes",
            int'({mult_load, div_load, mult_shift_ena, div_shift_ena,
                  dp_ena, data_resultRDY}), 0);
      tick();
      reset = 1'b0;
      repeat (25) tick();
      @(negedge clock);
      check("rm_nshift", n_ms, 8);
      check("rm_busy_end", int'(busy), 0);

      tick();
      check("sb_empty", sbq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
